fifo_rd_ctrl: RTL and testbench
===============================

Name: fifo_rd_ctrl

Overview:
Read-domain controller for the team's gray-pointer asynchronous FIFO. It owns the read pointer and synchronizes the write pointer with two flops. It computes a registered empty flag from the next read pointer and issues synchronous RAM reads. Read data is presented through a 2-entry valid/ready output buffer that sustains one word per cycle.

Parameters:
FIFO_DEPTH, 64, number of RAM entries; must be a power of two ≥ 4.
DATA_WIDTH, 32, word width.
AW = $clog2(FIFO_DEPTH) (localparam), RAM address width; PW = AW+1, pointer width.

Ports:
clk  input  1  read-domain clock; all state on rising edge
rst_n  input  1  synchronous active-low reset
wr_ptr_gray  input  PW  write pointer, gray coded, from write clock domain (asynchronous)
rd_ptr_gray  output  PW  registered gray read pointer, to write domain for full logic
rd_addr  output  AW  RAM read address = rbin[AW-1:0]
rd_en  output  1  RAM read strobe (combinational from registers and m_ready)
ram_rdata  input  DATA_WIDTH  RAM data, valid the cycle after the edge that sampled rd_en
m_data  output  DATA_WIDTH  head of output buffer
m_valid  output  1  head valid
m_ready  input  1  consumer accept
empty  output  1  registered FIFO-empty flag
rd_count  output  PW  registered fill estimate (words in RAM, excluding buffered/in-flight)

Behaviour:
- Reset (rst_n=0 at edge): rbin=0, rd_ptr_gray=0, wq1=wq2=0, empty=1, m_valid=0, occ=0, inflight=0, rd_count=0, m_data=0. Applies mid-operation; a RAM word landing after reset is discarded.
- Synchronizer: wq1<=wr_ptr_gray; wq2<=wq1. No other logic reads wq1.
- pop = m_valid & m_ready. occ ∈ {0,1,2} counts held words (head + skid). inflight ∈ {0,1}.
- rd_en = !empty & ((occ + inflight − pop) ≤ 1).
- On rd_en: rbin<=rbin+1 (mod 2^PW); rd_ptr_gray<=bin2gray(rbin+1); inflight<=1. Otherwise inflight<=0.
- Empty: rgray_next = bin2gray(rbin + rd_en); empty<=(rgray_next == wq2). Reading the last word sets empty at that same edge, so no over-read.
- rd_count <= gray2bin(wq2) − rbin_next, modulo 2^PW. Never exceeds FIFO_DEPTH for legal write-side behaviour.
- Landing: when inflight=1, ram_rdata is written at the edge.
  - Goes to the head if the head is empty after this cycle's pop; otherwise goes to skid.
  - On pop with skid valid, skid moves to head at the same edge.
  - Simultaneous pop + land + skid valid is impossible by the rd_en rule.
- m_data/m_valid are stable while m_valid & !m_ready. Data order is strictly FIFO.
- Wrap-around: rd_addr wraps at FIFO_DEPTH. The pointer MSB toggles every FIFO_DEPTH reads. rbin wraps at 2·FIFO_DEPTH with no discontinuity.
- Latency, from a wr_ptr_gray change to m_valid (m_ready don't-care, buffer empty):
  - edge 1: wq1; edge 2: wq2; edge 3: empty=0.
  - rd_en=1 in the cycle after edge 3; edge 4: inflight=1.
  - edge 5: m_valid=1.
- Throughput: one word per cycle while m_ready=1 and the FIFO is non-empty.
- With m_ready=0, at most 2 words are buffered, after which rd_en stays 0.

Test Plan:
1. Reset with wr_ptr_gray=0 → empty=1, m_valid=0, rd_en=0, rd_ptr_gray=0, rd_count=0 for 10 cycles.
2. Single word: wr_ptr_gray 0→1 (gray 0x01), m_ready=1 → empty=0 after edge 3. rd_en pulses once with rd_addr=0. m_valid high for exactly one cycle after edge 5, with m_data=RAM[0]. empty=1 again at the rd_en edge. rd_ptr_gray=0x01.
3. Burst: wr_ptr_gray jumps to gray(64) (=0x60), m_ready=1 → rd_en high 64 consecutive cycles with rd_addr 0..63. m_valid continuous 64 cycles, data in order. Final rd_ptr_gray=0x60, empty=1, rd_count=0.
4. Backpressure: 10 words available, m_ready=0 → exactly 2 reads issued, then occ=2 and rd_en=0, m_data=word0 stable. Raising m_ready → words 0..9 in order with no gaps and no duplicates.
5. Wrap: stream 200 words in chunks of 50 with random m_ready → rd_addr wraps 63→0. Pointer MSB toggles after reads 64, 128, 192. All 200 words are received in order and empty ends at 1.
6. Mid-burst reset: with 30 words pending and inflight=1, pull rst_n low for 1 cycle → all outputs return to reset values next edge. The landing word is discarded. After release and wr_ptr_gray=0 reapplied, no spurious m_valid.

Source files
------------

// File: rtl/fifo_rd_ctrl.sv
// Read side of the gray-pointer async FIFO: 2-flop write-pointer sync, registered empty, RAM read issue.
// wr_ptr change to m_valid in 5 edges; 2-entry head/skid buffer holds off rd_en once two words are owed.
module fifo_rd_ctrl #(
  parameter int FIFO_DEPTH = 64,
  parameter int DATA_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [$clog2(FIFO_DEPTH):0]       wr_ptr_gray,
  output logic [$clog2(FIFO_DEPTH):0]       rd_ptr_gray,
  output logic [$clog2(FIFO_DEPTH)-1:0]     rd_addr,
  output logic                              rd_en,
  input  logic [DATA_WIDTH-1:0]             ram_rdata,
  output logic [DATA_WIDTH-1:0]             m_data,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic                              empty,
  output logic [$clog2(FIFO_DEPTH):0]       rd_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0]         rbin;
  logic [PW-1:0]         wq1;
  logic [PW-1:0]         wq2;
  logic [1:0]            occ;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] skid;

  logic                  pop;
  logic [2:0]            owed;
  logic [1:0]            occ_after_pop;
  logic [PW-1:0]         rbin_next;
  logic [PW-1:0]         rgray_next;

  assign pop           = m_valid & m_ready;
  // Words already held or on their way, net of this cycle's pop; the buffer has room for two.
  assign owed          = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign rd_en         = !empty && (owed <= 3'd1);
  assign occ_after_pop = occ - {1'b0, pop};
  assign rbin_next     = rbin + {{(PW-1){1'b0}}, rd_en};
  assign rgray_next    = bin2gray(rbin_next);

  assign rd_addr = rbin[AW-1:0];
  assign m_data  = head;
  assign m_valid = (occ != 2'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rbin        <= '0;
      rd_ptr_gray <= '0;
      wq1         <= '0;
      wq2         <= '0;
      empty       <= 1'b1;
      occ         <= 2'd0;
      inflight    <= 1'b0;
      rd_count    <= '0;
      head        <= '0;
      skid        <= '0;
    end else begin
      wq1         <= wr_ptr_gray;
      wq2         <= wq1;
      rbin        <= rbin_next;
      rd_ptr_gray <= rgray_next;
      inflight    <= rd_en;
      // Compare against the post-read pointer so the last word raises empty at its own read edge.
      empty       <= (rgray_next == wq2);
      rd_count    <= gray2bin(wq2) - rbin_next;

      if (pop && (occ == 2'd2)) begin
        head <= skid;
      end
      if (inflight) begin
        if (occ_after_pop == 2'd0) begin
          head <= ram_rdata;
        end else begin
          skid <= ram_rdata;
        end
      end
      occ <= occ_after_pop + {1'b0, inflight};
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl: the bench plays writer and RAM, scoreboards read order and pointers.
module tb_fifo_rd_ctrl;

  localparam int DEPTH = 64;
  localparam int DW    = 32;

  logic          clk;
  logic          rst_n;
  logic [6:0]    wr_ptr_gray;
  logic [6:0]    rd_ptr_gray;
  logic [5:0]    rd_addr;
  logic          rd_en;
  logic [DW-1:0] ram_rdata;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          empty;
  logic [6:0]    rd_count;

  fifo_rd_ctrl #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_ptr_gray(wr_ptr_gray),
    .rd_ptr_gray(rd_ptr_gray),
    .rd_addr    (rd_addr),
    .rd_en      (rd_en),
    .ram_rdata  (ram_rdata),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .empty      (empty),
    .rd_count   (rd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] mem [DEPTH];
  logic [7:0]    epoch;
  int            wp;
  int            rx_idx;
  int            rd_idx;
  int            n_chk;
  int            n_pass;

  always @(posedge clk) begin
    if (rd_en) ram_rdata <= mem[rd_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  function automatic logic [6:0] g(input int b);
    logic [6:0] v;
    v = b[6:0];
    return v ^ (v >> 1);
  endfunction

  function automatic logic [31:0] word(input int n);
    logic [15:0] nn;
    nn = n[15:0];
    return {epoch, 8'h5A, nn};
  endfunction

  // Consumer scoreboard: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      rx_idx = 0;
    end else if (m_valid && m_ready) begin
      chk("rx_data", m_data, word(rx_idx));
      rx_idx++;
    end
  end

  // RAM-read tracker: every read must hit the next address, and the gray pointer must follow the reads.
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_idx = 0;
    end else begin
      chk("rd_ptr", {25'd0, rd_ptr_gray}, {25'd0, g(rd_idx)});
      if (rd_en) begin
        chk("rd_addr", {26'd0, rd_addr}, rd_idx % DEPTH);
        rd_idx++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    m_ready     = 1'b0;
    wr_ptr_gray = '0;
    wp          = 0;
    epoch       = epoch + 8'd1;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic write_words(input int n);
    for (int k = 0; k < n; k++) begin
      mem[wp % DEPTH] = word(wp);
      wp++;
    end
    wr_ptr_gray = g(wp);
  endtask

  task automatic wait_rx(input int target, input bit rnd);
    int b;
    b = 0;
    while (rx_idx < target && b < 3000) begin
      if (rnd) m_ready = 1'($urandom_range(0, 1));
      step();
      b++;
    end
    chk("rx_cnt", rx_idx, target);
  endtask

  initial begin
    int nrd;
    n_chk = 0; n_pass = 0; epoch = 8'd0;
    rst_n = 1'b0; m_ready = 1'b0; wr_ptr_gray = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;

    // 1: idle after reset
    do_reset();
    for (int i = 0; i < 10; i++) begin
      chk("t1_empty", empty, 1);
      chk("t1_vld", m_valid, 0);
      chk("t1_rden", rd_en, 0);
      chk("t1_rdptr", rd_ptr_gray, 0);
      chk("t1_cnt", rd_count, 0);
      step();
    end

    // 2: single word latency
    do_reset();
    m_ready = 1'b1;
    write_words(1);
    step(); chk("t2_e1_empty", empty, 1);
    step(); chk("t2_e2_empty", empty, 1);
    step();
    chk("t2_e3_empty", empty, 0);
    chk("t2_e3_rden", rd_en, 1);
    chk("t2_e3_addr", rd_addr, 0);
    chk("t2_e3_cnt", rd_count, 1);
    step();
    chk("t2_e4_empty", empty, 1);
    chk("t2_e4_rden", rd_en, 0);
    chk("t2_e4_rdptr", rd_ptr_gray, 7'h01);
    chk("t2_e4_vld", m_valid, 0);
    step();
    chk("t2_e5_vld", m_valid, 1);
    chk("t2_e5_data", m_data, word(0));
    step();
    chk("t2_e6_vld", m_valid, 0);
    chk("t2_rx", rx_idx, 1);

    // 3: full-depth burst
    do_reset();
    m_ready = 1'b1;
    write_words(64);
    chk("t3_wptr", wr_ptr_gray, 7'h60);
    step(); step(); step();
    for (int i = 0; i < 64; i++) begin
      chk("t3_rden", rd_en, 1);
      chk("t3_addr", rd_addr, i);
      chk("t3_vld", m_valid, i >= 2);
      step();
    end
    chk("t3_rden_off", rd_en, 0);
    chk("t3_vld_tail0", m_valid, 1);
    step();
    chk("t3_vld_tail1", m_valid, 1);
    step();
    chk("t3_vld_off", m_valid, 0);
    chk("t3_rdptr", rd_ptr_gray, 7'h60);
    chk("t3_empty", empty, 1);
    chk("t3_cnt", rd_count, 0);
    chk("t3_rx", rx_idx, 64);

    // 4: backpressure with 10 words
    do_reset();
    write_words(10);
    step(); step(); step();
    nrd = 0;
    for (int i = 0; i < 12; i++) begin
      nrd += int'(rd_en);
      step();
    end
    chk("t4_reads", nrd, 2);
    chk("t4_cnt", rd_count, 8);
    for (int i = 0; i < 4; i++) begin
      chk("t4_hold_vld", m_valid, 1);
      chk("t4_hold_data", m_data, word(0));
      chk("t4_hold_rden", rd_en, 0);
      step();
    end
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("t4_stream_vld", m_valid, 1);
      step();
    end
    chk("t4_vld_off", m_valid, 0);
    chk("t4_rx", rx_idx, 10);
    chk("t4_empty", empty, 1);

    // 5: 200 words across pointer wraps, random consumer
    do_reset();
    for (int c = 0; c < 4; c++) begin
      write_words(50);
      wait_rx(50 * (c + 1), 1'b1);
    end
    m_ready = 1'b1;
    step(); step(); step();
    chk("t5_empty", empty, 1);
    chk("t5_rdptr", rd_ptr_gray, g(200));
    chk("t5_cnt", rd_count, 0);
    chk("t5_reads", rd_idx, 200);

    // 6: reset in the middle of a burst with a read in flight
    do_reset();
    m_ready = 1'b1;
    write_words(30);
    step(); step(); step(); step(); step();
    chk("t6_pre_vld", m_valid, 1);
    rst_n = 1'b0;
    step();
    chk("t6_empty", empty, 1);
    chk("t6_vld", m_valid, 0);
    chk("t6_rden", rd_en, 0);
    chk("t6_rdptr", rd_ptr_gray, 0);
    chk("t6_cnt", rd_count, 0);
    chk("t6_data", m_data, 0);
    rst_n = 1'b1;
    wr_ptr_gray = '0;
    for (int i = 0; i < 10; i++) begin
      chk("t6_post_vld", m_valid, 0);
      chk("t6_post_empty", empty, 1);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
